// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the MIPS subset datapath (lw, sw, beq, addi, R-type, j).
// Walks each instruction through fetch/decode/execute/memory/writeback, one datapath step
// per cycle, stalling on the memory ready handshake.
// Optional feature: define MULTICYCLE_JUMP_EN to implement the j instruction (JUMP state).
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instr_op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_retired,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  state_e state_q, state_d;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; everything is held at 0 while rst is high.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_retired = 1'b0;
    illegal_op    = 1'b0;
    state         = 4'd0;
    if (!rst) begin
      state = state_q;
      unique case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) state_d = StDecode;
        end
        StDecode: begin
          // Precompute the branch target into ALUOut.
          alu_src_b = 2'b11;
          case (instr_op)
            OpRtype:    state_d = StExec;
            OpLw, OpSw: state_d = StMemAddr;
            OpBeq:      state_d = StBranch;
            OpAddi:     state_d = StAddiEx;
`ifdef MULTICYCLE_JUMP_EN
            OpJ:        state_d = StJump;
`endif
            default: begin
              illegal_op = 1'b1;
              state_d    = StFetch;
            end
          endcase
        end
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (instr_op == OpLw)      state_d = StMemRd;
          else if (instr_op == OpSw) state_d = StMemWr;
          else                       state_d = StFetch;
        end
        StMemRd: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_d = StMemWb;
        end
        StMemWb: begin
          reg_write     = 1'b1;
          mem_to_reg    = 1'b1;
          instr_retired = 1'b1;
          state_d       = StFetch;
        end
        StMemWr: begin
          mem_write     = 1'b1;
          iord          = 1'b1;
          instr_retired = mem_ready;
          if (mem_ready) state_d = StFetch;
        end
        StExec: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = StRWb;
        end
        StRWb: begin
          reg_write     = 1'b1;
          reg_dst       = 1'b1;
          instr_retired = 1'b1;
          state_d       = StFetch;
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_retired = 1'b1;
          state_d       = StFetch;
        end
        StAddiEx: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = StAddiWb;
        end
        StAddiWb: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          state_d       = StFetch;
        end
`ifdef MULTICYCLE_JUMP_EN
        StJump: begin
          pc_write      = 1'b1;
          pc_source     = 2'b10;
          instr_retired = 1'b1;
          state_d       = StFetch;
        end
`endif
        // Unused codes recover to FETCH with all outputs low.
        default: state_d = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus hand-written stall sequences.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_retired, illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk           (clk),
    .rst           (rst),
    .instr_op      (instr_op),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_retired (instr_retired),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {pcw,pcwc,iord,mrd,mwr,irw,m2r,rdst,rwr,asa}_{asb}_{aop}_{psrc}_{ret,ill}
  logic [17:0] outs;
  assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_retired,
                 illegal_op};

  localparam logic [17:0] OZero   = 18'b0000000000_00_00_00_00;
  localparam logic [17:0] OFetchR = 18'b1001010000_01_00_00_00;
  localparam logic [17:0] OFetchN = 18'b0001000000_01_00_00_00;
  localparam logic [17:0] ODecode = 18'b0000000000_11_00_00_00;
  localparam logic [17:0] ODecIll = 18'b0000000000_11_00_00_01;
  localparam logic [17:0] OMemAdr = 18'b0000000001_10_00_00_00;
  localparam logic [17:0] OMemRd  = 18'b0011000000_00_00_00_00;
  localparam logic [17:0] OMemWb  = 18'b0000001010_00_00_00_10;
  localparam logic [17:0] OMemWrR = 18'b0010100000_00_00_00_10;
  localparam logic [17:0] OExec   = 18'b0000000001_00_10_00_00;
  localparam logic [17:0] ORWb    = 18'b0000000110_00_00_00_10;
  localparam logic [17:0] OBranch = 18'b0100000001_00_01_01_10;
  localparam logic [17:0] OAddiWb = 18'b0000000010_00_00_00_10;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [17:0] OJump   = 18'b1000000000_00_00_10_10;
`endif

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpBad  = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  exp_state;
    logic [17:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [17:0] o);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.exp_state = st; v.exp_out = o;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs, then move to the sampling point (falling edge).
  task automatic drive(input logic r, input logic [5:0] op, input logic mr);
    rst = r; instr_op = op; mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr_op = OpR; mem_ready = 1'b1;

    // Reset held two cycles: everything forced low.
    add(1, OpR, 1, 4'd0, OZero);
    add(1, OpR, 1, 4'd0, OZero);
    // R-type; mem_ready toggled where it must be ignored.
    add(0, OpR, 1, 4'd0, OFetchR);
    add(0, OpR, 0, 4'd1, ODecode);
    add(0, OpR, 0, 4'd6, OExec);
    add(0, OpR, 1, 4'd7, ORWb);
    // lw with two stall cycles in MEM_RD.
    add(0, OpLw, 1, 4'd0, OFetchR);
    add(0, OpLw, 1, 4'd1, ODecode);
    add(0, OpLw, 1, 4'd2, OMemAdr);
    add(0, OpLw, 0, 4'd3, OMemRd);
    add(0, OpLw, 0, 4'd3, OMemRd);
    add(0, OpLw, 1, 4'd3, OMemRd);
    add(0, OpLw, 0, 4'd4, OMemWb);
    // sw, zero wait.
    add(0, OpSw, 1, 4'd0, OFetchR);
    add(0, OpSw, 1, 4'd1, ODecode);
    add(0, OpSw, 1, 4'd2, OMemAdr);
    add(0, OpSw, 1, 4'd5, OMemWrR);
    // beq.
    add(0, OpBeq, 1, 4'd0, OFetchR);
    add(0, OpBeq, 1, 4'd1, ODecode);
    add(0, OpBeq, 0, 4'd8, OBranch);
    // addi.
    add(0, OpAddi, 1, 4'd0, OFetchR);
    add(0, OpAddi, 1, 4'd1, ODecode);
    add(0, OpAddi, 1, 4'd9, OMemAdr);
    add(0, OpAddi, 1, 4'd10, OAddiWb);
    // Illegal opcode, then a fetch stall.
    add(0, OpBad, 1, 4'd0, OFetchR);
    add(0, OpBad, 1, 4'd1, ODecIll);
    add(0, OpBad, 0, 4'd0, OFetchN);
    add(0, OpBad, 1, 4'd0, OFetchR);
    // Reset mid-lw while in MEM_RD: no further memory/regfile activity.
    add(0, OpLw, 1, 4'd1, ODecode);
    add(0, OpLw, 1, 4'd2, OMemAdr);
    add(1, OpLw, 1, 4'd0, OZero);
    add(0, OpLw, 1, 4'd0, OFetchR);
    // j
`ifdef MULTICYCLE_JUMP_EN
    add(0, OpJ, 1, 4'd1, ODecode);
    add(0, OpJ, 1, 4'd11, OJump);
    add(0, OpJ, 1, 4'd0, OFetchR);
`else
    add(0, OpJ, 1, 4'd1, ODecIll);
    add(0, OpJ, 0, 4'd0, OFetchN);
    add(0, OpJ, 1, 4'd0, OFetchR);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].mr);
      chk($sformatf("vec%0d", i), {10'd0, state, outs}, {10'd0, vecs[i].exp_state, vecs[i].exp_out});
      advance();
    end

    // Hand sequence: sw (now in DECODE) with three stall cycles in MEM_WR.
    drive(0, OpSw, 1);
    chk("sw_decode_state", {28'd0, state}, 32'd1);
    advance();
    drive(0, OpSw, 1);
    chk("sw_memaddr_state", {28'd0, state}, 32'd2);
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, OpSw, 0);
      chk($sformatf("sw_stall%0d", k), {28'd0, state, mem_write, mem_read, instr_retired, iord},
          {28'd5, 4'b1001});
      advance();
    end
    drive(0, OpSw, 1);
    chk("sw_complete", {28'd0, state, mem_write, mem_read, instr_retired, iord},
        {28'd5, 4'b1011});
    advance();

    // Hand sequence: beq issued after long fetch stall; bounded wait for BRANCH.
    begin
      int cyc;
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      for (int k = 0; k < 4; k++) begin
        drive(0, OpBeq, 0);
        advance();
      end
      while (!seen && cyc < 10) begin
        drive(0, OpBeq, 1);
        if (state == 4'd8) seen = 1'b1;
        else begin
          advance();
          cyc++;
        end
      end
      chk("beq_reached_branch", {31'd0, seen}, 32'd1);
      chk("beq_cycles_after_stall", cyc, 32'd2);
      chk("beq_pcwc", {30'd0, pc_write_cond, pc_write}, 32'b10);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
